// File: rtl/sc_stream_generator.sv
// Dual-channel stochastic number generator: turns two unsigned values into
// unipolar bitstreams by comparing each value against a free-running Galois LFSR.
module sc_stream_generator #(
  parameter int               WIDTH      = 8,
  parameter int               STREAM_LEN = 255,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter logic [WIDTH-1:0] SEED_A     = 8'h01,
  parameter logic [WIDTH-1:0] SEED_B     = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  input  logic             en,
  output logic             ready,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_valid,
  output logic             bit_last
);

  localparam int CNT_W = (STREAM_LEN < 1) ? 1 : $clog2(STREAM_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STREAM_LEN - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0] val_a_q, val_a_d;
  logic [WIDTH-1:0] val_b_q, val_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_a_q, bit_a_d;
  logic             bit_b_q, bit_b_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_last_q, bit_last_d;

  // Right-shifting Galois step; a nonzero state never reaches zero.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ TAPS) : shifted;
  endfunction

  always_comb begin
    state_d     = state_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    cnt_d       = cnt_q;
    bit_a_d     = bit_a_q;
    bit_b_d     = bit_b_q;
    bit_valid_d = 1'b0;
    bit_last_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          val_a_d  = value_a;
          val_b_d  = value_b;
          lfsr_a_d = SEED_A;
          lfsr_b_d = SEED_B;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      default: begin
        if (en) begin
          bit_a_d     = (lfsr_a_q <= val_a_q);
          bit_b_d     = (lfsr_b_q <= val_b_q);
          bit_valid_d = 1'b1;
          lfsr_a_d    = galois_step(lfsr_a_q);
          lfsr_b_d    = galois_step(lfsr_b_q);
          cnt_d       = cnt_q + CNT_W'(1);
          // Returning to IDLE on the last bit lets ready rise alongside bit_last.
          if (cnt_q == LAST_CNT) begin
            bit_last_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_a_q    <= SEED_A;
      lfsr_b_q    <= SEED_B;
      val_a_q     <= '0;
      val_b_q     <= '0;
      cnt_q       <= '0;
      bit_a_q     <= 1'b0;
      bit_b_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      cnt_q       <= cnt_d;
      bit_a_q     <= bit_a_d;
      bit_b_q     <= bit_b_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign bit_a     = bit_a_q;
  assign bit_b     = bit_b_q;
  assign bit_valid = bit_valid_q;
  assign bit_last  = bit_last_q;

endmodule
